fc_layer_stream: RTL and testbench

//  Parametrised, sequential fully-connected layer. One signed MAC per accepted weight word.

---
 rtl/fc_layer_stream_pkg.sv | 30 +++
 rtl/fc_layer_stream_if.sv | 27 ++
 rtl/fc_layer_stream_mac_sat.sv | 35 +++
 rtl/fc_layer_stream.sv | 113 +++++++++++
 tb/tb_fc_layer_stream.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_layer_stream_pkg.sv
// Shared definitions for the streaming layer blocks: FSM states, word sizing
// and the output saturate/ReLU stage that other layers reuse.
package fc_layer_stream_pkg;

    typedef enum logic [1:0] {IDLE, BIAS, MAC, OUT} state_t;

    localparam int BYTE_BITS = 8;

    function automatic int word_bytes(input int bits);
        return bits / BYTE_BITS;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp v to a signed 'bits'-wide range; negative results go to zero when relu is set.
    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                   input int bits, input logic relu);
        logic signed [63:0] hi, lo, r;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = ~hi;
        if (relu && v < 0)  r = '0;
        else if (v > hi)    r = hi;
        else if (v < lo)    r = lo;
        else                r = v;
        return r;
    endfunction

endpackage

// File: rtl/fc_layer_stream_if.sv
// Memory read port and result stream of the fully-connected layer.
interface fc_layer_stream_if #(
    parameter int ADDR_BITS  = 24,
    parameter int ACTIV_BITS = 16,
    parameter int IDX_BITS   = 6
);
    logic                  mem_req;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [ACTIV_BITS-1:0] mem_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACTIV_BITS-1:0] out_data;
    logic [IDX_BITS-1:0]   out_index;
    logic                  out_last;

    modport master (
        output mem_req, mem_addr, out_valid, out_data, out_index, out_last,
        input  mem_gnt, mem_rvalid, mem_rdata, out_ready
    );

    modport slave (
        input  mem_req, mem_addr, out_valid, out_data, out_index, out_last,
        output mem_gnt, mem_rvalid, mem_rdata, out_ready
    );
endinterface

// File: rtl/fc_layer_stream_mac_sat.sv
// Accumulator datapath: bias load, signed MAC and the scaled/saturated output.
// ACC_BITS must not exceed 64.
module fc_mac_sat
    import fc_layer_stream_pkg::*;
#(
    parameter int ACTIV_BITS = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_BITS   = 48
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         mac,
    input  logic                         relu,
    input  logic signed [ACTIV_BITS-1:0] word,
    input  logic signed [ACTIV_BITS-1:0] x,
    output logic        [ACTIV_BITS-1:0] y
);
    logic signed [2*ACTIV_BITS-1:0] prod;
    logic signed [ACC_BITS-1:0]     acc, shifted;
    logic signed [63:0]             res;

    assign prod = word * x;

    always_ff @(posedge clk) begin
        if (!rst_n)    acc <= '0;
        else if (load) acc <= ACC_BITS'(word) <<< FRAC_BITS;
        else if (mac)  acc <= acc + ACC_BITS'(prod);
    end

    assign shifted = acc >>> FRAC_BITS;
    assign res     = sat_relu(64'(shifted), ACTIV_BITS, relu);
    assign y       = ACTIV_BITS'(res);

endmodule

// File: rtl/fc_layer_stream.sv
// Sequential fully-connected layer: fetches bias then one weight row per neuron
// over a single-outstanding read port and streams one saturated result per neuron.
module fc_layer_stream
    import fc_layer_stream_pkg::*;
#(
    parameter int INPUT_SIZE  = 320,
    parameter int OUTPUT_SIZE = 64,
    parameter int ACTIV_BITS  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_BITS    = 48,
    parameter int ADDR_BITS   = 24
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             relu_en,
    input  logic [INPUT_SIZE*ACTIV_BITS-1:0] data_in,
    input  logic [ADDR_BITS-1:0]             weight_base,
    input  logic [ADDR_BITS-1:0]             bias_base,
    output logic                             busy,
    fc_layer_stream_if.master                bus
);
    localparam int IDX_BITS = idx_width(OUTPUT_SIZE);
    localparam int J_BITS   = idx_width(INPUT_SIZE);
    localparam logic [ADDR_BITS-1:0] STEP = ADDR_BITS'(word_bytes(ACTIV_BITS));

    state_t state, state_nx;

    logic [INPUT_SIZE-1:0][ACTIV_BITS-1:0] x_q;
    logic                 relu_q, pend;
    logic [ADDR_BITS-1:0] waddr, baddr;
    logic [IDX_BITS-1:0]  i_q;
    logic [J_BITS-1:0]    j_q;
    logic                 last_i, last_j, grant, rd_done, handshake;

    assign last_i    = (i_q == IDX_BITS'(OUTPUT_SIZE - 1));
    assign last_j    = (j_q == J_BITS'(INPUT_SIZE - 1));
    assign grant     = bus.mem_req && bus.mem_gnt;
    assign rd_done   = pend && bus.mem_rvalid;
    assign handshake = (state == OUT) && bus.out_ready;

    // Request straight from registered state so a word costs only grant + rvalid.
    assign bus.mem_req   = ((state == BIAS) || (state == MAC)) && !pend;
    assign bus.mem_addr  = !bus.mem_req ? '0 : (state == BIAS) ? baddr : waddr;
    assign bus.out_valid = (state == OUT);
    assign bus.out_last  = (state == OUT) && last_i;
    assign bus.out_index = i_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = BIAS;
            BIAS:    if (rd_done) state_nx = MAC;
            MAC:     if (rd_done && last_j) state_nx = OUT;
            OUT:     if (bus.out_ready) state_nx = last_i ? IDLE : BIAS;
            default: state_nx = IDLE;
        endcase
    end

    // Weights are row-major and contiguous, so one running pointer covers all rows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q    <= '0;
            relu_q <= 1'b0;
            waddr  <= '0;
            baddr  <= '0;
            i_q    <= '0;
            j_q    <= '0;
            pend   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                x_q    <= data_in;
                relu_q <= relu_en;
                waddr  <= weight_base;
                baddr  <= bias_base;
                i_q    <= '0;
            end
            if (grant)        pend <= 1'b1;
            else if (rd_done) pend <= 1'b0;
            if (rd_done && state == BIAS) begin
                baddr <= baddr + STEP;
                j_q   <= '0;
            end
            if (rd_done && state == MAC) begin
                waddr <= waddr + STEP;
                if (!last_j) j_q <= j_q + J_BITS'(1);
            end
            if (handshake && !last_i) i_q <= i_q + IDX_BITS'(1);
        end
    end

    fc_mac_sat #(
        .ACTIV_BITS (ACTIV_BITS),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_BITS   (ACC_BITS)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (rd_done && state == BIAS),
        .mac   (rd_done && state == MAC),
        .relu  (relu_q),
        .word  (bus.mem_rdata),
        .x     (x_q[j_q]),
        .y     (bus.out_data)
    );

endmodule

// File: tb/tb_fc_layer_stream.sv
// Randomised bench for fc_layer_stream against a plain-arithmetic layer model,
// with a stalling memory responder and a backpressuring result sink.
module tb_fc_layer_stream;
    localparam int IS = 4;
    localparam int OS = 2;

    logic        clk, rst_n, start, relu_en, busy;
    logic [63:0] data_in;
    logic [23:0] weight_base, bias_base;

    fc_layer_stream_if #(.ADDR_BITS(24), .ACTIV_BITS(16), .IDX_BITS(1)) bus ();

    fc_layer_stream #(
        .INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .ACTIV_BITS(16),
        .FRAC_BITS(8), .ACC_BITS(48), .ADDR_BITS(24)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
        .data_in(data_in), .weight_base(weight_base), .bias_base(bias_base),
        .busy(busy), .bus(bus)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [15:0] mem [0:1023];
    logic [23:0] addr_q [$];
    int          gnt_max = 0, lat_max = 1;
    int          viol_addr = 0, viol_out = 0;

    initial begin
        int gwait, lat;
        bit pend_m, prev_req, prev_gnt;
        logic [23:0] paddr, prev_addr;
        gwait = 0; lat = 0; pend_m = 0; prev_req = 0; prev_gnt = 0;
        paddr = '0; prev_addr = '0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.mem_gnt = 0; bus.mem_rvalid = 0;
                pend_m = 0; prev_req = 0; prev_gnt = 0; gwait = 0;
            end else begin
                if (bus.mem_gnt) begin
                    pend_m = 1;
                    lat = $urandom_range(lat_max, 1);
                end else if (bus.mem_rvalid) pend_m = 0;
                if (prev_req && !prev_gnt && (!bus.mem_req || bus.mem_addr != prev_addr))
                    viol_addr++;
                if (bus.mem_req && pend_m) viol_out++;
                prev_req = bus.mem_req;
                prev_addr = bus.mem_addr;
                bus.mem_gnt = 0; bus.mem_rvalid = 0;
                if (pend_m) begin
                    lat--;
                    if (lat == 0) begin
                        bus.mem_rvalid = 1;
                        bus.mem_rdata = mem[paddr[9:0]];
                    end
                end else if (bus.mem_req) begin
                    if (gwait == 0) begin
                        bus.mem_gnt = 1;
                        paddr = bus.mem_addr;
                        addr_q.push_back(bus.mem_addr);
                        gwait = $urandom_range(gnt_max, 0);
                    end else gwait--;
                end
                prev_gnt = bus.mem_gnt;
            end
        end
    end

    // ---------------- result sink ----------------
    logic [15:0] got_d [$];
    logic        got_i [$];
    logic        got_l [$];
    int          bp_len = 0, viol_bp = 0;

    initial begin
        int bp_cnt;
        bit bp_seen;
        logic [15:0] bp_data;
        logic        bp_idx;
        bp_cnt = 0; bp_seen = 0; bp_data = '0; bp_idx = 0;
        bus.out_ready = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !busy) begin
                bus.out_ready = rst_n ? 1'($urandom_range(1, 0)) : 1'b0;
                bp_cnt = 0; bp_seen = 0;
            end else if (bus.out_valid) begin
                if (bp_cnt < bp_len) begin
                    bus.out_ready = 0;
                    if (!bp_seen) begin
                        bp_seen = 1; bp_data = bus.out_data; bp_idx = bus.out_index;
                    end else if (bus.out_data != bp_data || bus.out_index != bp_idx) viol_bp++;
                    if (bus.mem_req) viol_bp++;
                    bp_cnt++;
                end else begin
                    bus.out_ready = 1;
                    if (bp_seen && (bus.out_data != bp_data || bus.out_index != bp_idx)) viol_bp++;
                    bp_seen = 0;
                    bp_cnt = bp_len;
                    got_d.push_back(bus.out_data);
                    got_i.push_back(bus.out_index);
                    got_l.push_back(bus.out_last);
                end
            end else begin
                if (bp_seen) viol_bp++;
                bus.out_ready = 1'($urandom_range(1, 0));
            end
        end
    end

    // ---------------- reference model ----------------
    logic [23:0] wb_cur, bb_cur;
    logic [15:0] x_cur [IS];
    bit          relu_cur;

    function automatic logic [15:0] ref_out(input int i);
        longint acc, y;
        logic [23:0] a;
        a = bb_cur + 24'(2 * i);
        acc = longint'($signed(mem[a[9:0]])) * 256;
        for (int j = 0; j < IS; j++) begin
            a = wb_cur + 24'(2 * (i * IS + j));
            acc += longint'($signed(mem[a[9:0]])) * longint'($signed(x_cur[j]));
        end
        y = acc >>> 8;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        if (relu_cur && y < 0) y = 0;
        return y[15:0];
    endfunction

    function automatic logic [23:0] exp_addr(input int k);
        int i, r;
        i = k / (IS + 1);
        r = k % (IS + 1);
        return (r == 0) ? bb_cur + 24'(2 * i) : wb_cur + 24'(2 * (i * IS + r - 1));
    endfunction

    function automatic logic [15:0] got_at(input int k);
        return (k < got_d.size()) ? got_d[k] : 16'hxxxx;
    endfunction

    task automatic fill(input logic [23:0] wb, input logic [23:0] bb, input bit rnd,
                        input logic [15:0] wv, input logic [15:0] bv);
        logic [23:0] a;
        for (int i = 0; i < OS; i++) begin
            a = bb + 24'(2 * i);
            mem[a[9:0]] = rnd ? 16'($urandom) : bv;
        end
        for (int k = 0; k < OS * IS; k++) begin
            a = wb + 24'(2 * k);
            mem[a[9:0]] = rnd ? 16'($urandom) : wv;
        end
    endtask

    task automatic set_x(input bit rnd, input logic [15:0] v);
        for (int j = 0; j < IS; j++) x_cur[j] = rnd ? 16'($urandom) : v;
    endtask

    task automatic launch(input logic [23:0] wb, input logic [23:0] bb, input bit relu);
        wb_cur = wb; bb_cur = bb; relu_cur = relu;
        @(negedge clk);
        weight_base = wb; bias_base = bb; relu_en = relu;
        for (int j = 0; j < IS; j++) data_in[j*16 +: 16] = x_cur[j];
        start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic run_pass(input logic [23:0] wb, input logic [23:0] bb, input bit relu,
                            input bit mid, input bit endstart, output int base);
        int a0, va0, vo0, vb0, cyc;
        a0 = addr_q.size(); base = got_d.size();
        va0 = viol_addr; vo0 = viol_out; vb0 = viol_bp;
        launch(wb, bb, relu);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            start = 0;
            if (!busy || cyc > 3000) break;
            if (mid && cyc == 7) begin
                start = 1; relu_en = ~relu;
                data_in = {$urandom(), $urandom()};
                weight_base = 24'h000155; bias_base = 24'h000255;
            end
            if (endstart && bus.out_valid && bus.out_last) start = 1;
        end
        chk("pass_in_time", cyc <= 3000, 1);
        repeat (2) @(negedge clk);
        chk("idle_after_pass", busy, 0);
        chk("out_count", got_d.size() - base, OS);
        for (int i = 0; i < OS; i++) begin
            chk("out_data", got_at(base + i), ref_out(i));
            if (base + i < got_i.size()) begin
                chk("out_index", got_i[base + i], i);
                chk("out_last", got_l[base + i], i == OS - 1);
            end
        end
        chk("addr_count", addr_q.size() - a0, OS * (IS + 1));
        for (int k = 0; k < OS * (IS + 1); k++)
            if (a0 + k < addr_q.size()) chk("addr_order", addr_q[a0 + k], exp_addr(k));
        chk("addr_stable", viol_addr - va0, 0);
        chk("one_outstanding", viol_out - vo0, 0);
        chk("bp_hold", viol_bp - vb0, 0);
    endtask

    initial begin
        int b, cyc, a0;
        rst_n = 0; start = 0; relu_en = 0; data_in = '0;
        weight_base = '0; bias_base = '0;
        wb_cur = '0; bb_cur = '0; relu_cur = 0;
        set_x(0, 16'h0000);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_index", bus.out_index, 0);
        rst_n = 1;

        // basic pass with an immediate-grant memory
        set_x(0, 16'h0100);
        fill(24'h000000, 24'h000100, 0, 16'h0100, 16'h0080);
        run_pass(24'h000000, 24'h000100, 0, 0, 0, b);
        chk("basic_y0", got_at(b), 16'h0480);
        chk("basic_y1", got_at(b + 1), 16'h0480);

        // negative result with and without ReLU
        fill(24'h000000, 24'h000100, 0, 16'hFF00, 16'h0000);
        run_pass(24'h000000, 24'h000100, 0, 0, 0, b);
        chk("neg_y0", got_at(b), 16'hFC00);
        run_pass(24'h000000, 24'h000100, 1, 0, 0, b);
        chk("relu_y0", got_at(b), 16'h0000);

        // saturation at both rails
        set_x(0, 16'h7FFF);
        fill(24'h000000, 24'h000100, 0, 16'h7FFF, 16'h0000);
        run_pass(24'h000000, 24'h000100, 0, 0, 0, b);
        chk("sat_hi", got_at(b), 16'h7FFF);
        fill(24'h000000, 24'h000100, 0, 16'h8000, 16'h0000);
        run_pass(24'h000000, 24'h000100, 0, 0, 0, b);
        chk("sat_lo", got_at(b), 16'h8000);

        // memory stalls, weight addresses wrapping through zero
        gnt_max = 7; lat_max = 5;
        set_x(0, 16'h0100);
        fill(24'hFFFFFA, 24'h000200, 0, 16'h0100, 16'h0080);
        run_pass(24'hFFFFFA, 24'h000200, 0, 0, 0, b);
        chk("stall_y0", got_at(b), 16'h0480);
        chk("stall_y1", got_at(b + 1), 16'h0480);

        // backpressure on neuron 0
        gnt_max = 0; lat_max = 1; bp_len = 10;
        fill(24'h000000, 24'h000100, 0, 16'h0100, 16'h0080);
        run_pass(24'h000000, 24'h000100, 0, 0, 0, b);
        chk("bp_y0", got_at(b), 16'h0480);
        bp_len = 0;

        // start mid-pass and coincident with the final handshake
        run_pass(24'h000000, 24'h000100, 0, 1, 0, b);
        run_pass(24'h000000, 24'h000100, 0, 0, 1, b);

        // reset while accumulating neuron 1, then a clean pass
        gnt_max = 2; lat_max = 3;
        a0 = addr_q.size();
        launch(24'h000000, 24'h000100, 0);
        cyc = 0;
        while (addr_q.size() < a0 + IS + 3 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_neuron1", cyc < 2000, 1);
        rst_n = 0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_mem_req", bus.mem_req, 0);
        @(negedge clk);
        rst_n = 1;
        run_pass(24'h000000, 24'h000100, 0, 0, 0, b);
        chk("after_rst_y1", got_at(b + 1), 16'h0480);

        // random layers, random bases, random stalls
        for (int t = 0; t < 8; t++) begin
            logic [23:0] wb, bb;
            gnt_max = $urandom_range(3, 0); lat_max = $urandom_range(4, 1);
            wb = 24'($urandom); bb = 24'($urandom);
            set_x(1, 16'h0000);
            fill(wb, bb, 1, 16'h0000, 16'h0000);
            run_pass(wb, bb, 1'($urandom_range(1, 0)), 0, 0, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
